// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one RAM port between instruction fetch and data memory
// Data has priority; a streak counter forces an instruction grant after MAX_DSTREAK data grants.
module mem_arbiter #(
    parameter int MAX_DSTREAK = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        ihit,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dhit,
    output logic        ram_ren,
    output logic        ram_wen,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_store,
    input  logic [31:0] ram_load,
    input  logic        ram_ready
);
    typedef enum logic [1:0] {IDLE, IACC, DRD, DWR} state_t;

    state_t      state, next_state;
    logic [3:0]  dstreak, next_dstreak;
    logic [31:0] next_addr, next_store;
    logic        d_req, starve, grant_i, grant_d;

    assign d_req  = dREN | dWEN;
    assign starve = iREN && (dstreak == 4'(MAX_DSTREAK));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            dstreak   <= 4'd0;
            ram_addr  <= 32'd0;
            ram_store <= 32'd0;
        end else begin
            state     <= next_state;
            dstreak   <= next_dstreak;
            ram_addr  <= next_addr;
            ram_store <= next_store;
        end
    end

    always_comb begin
        grant_i      = 1'b0;
        grant_d      = 1'b0;
        next_state   = state;
        next_dstreak = dstreak;
        next_addr    = ram_addr;
        next_store   = ram_store;
        // On completion the requester just served sits out; the other one chains in directly.
        case (state)
            IDLE: begin
                if (d_req && !starve) grant_d = 1'b1;
                else if (iREN)        grant_i = 1'b1;
            end
            IACC: begin
                if (ram_ready) begin
                    next_state = IDLE;
                    grant_d    = d_req;
                end
            end
            DRD, DWR: begin
                if (ram_ready) begin
                    next_state = IDLE;
                    grant_i    = iREN;
                end
            end
            default: next_state = IDLE;
        endcase
        if (grant_d) begin
            next_state = dWEN ? DWR : DRD;
            next_addr  = daddr;
            next_store = dstore;
            if (!iREN)
                next_dstreak = 4'd0;
            else if (dstreak != 4'(MAX_DSTREAK))
                next_dstreak = dstreak + 4'd1;
        end
        if (grant_i) begin
            next_state   = IACC;
            next_addr    = iaddr;
            next_dstreak = 4'd0;
        end
    end

    assign ram_ren = (state == IACC) || (state == DRD);
    assign ram_wen = (state == DWR);
    assign ihit    = (state == IACC) && ram_ready && iREN;
    assign dhit    = ((state == DRD) || (state == DWR)) && ram_ready && d_req;
    assign iload   = ihit ? ram_load : 32'd0;
    assign dload   = (dhit && (state == DRD)) ? ram_load : 32'd0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector table, reset abort sequence and randomized model check for mem_arbiter
module tb_mem_arbiter;
    localparam int MAXD = 4;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN, ram_ready;
    logic [31:0] iaddr, daddr, dstore, ram_load;
    logic [31:0] iload, dload, ram_addr, ram_store;
    logic        ihit, dhit, ram_ren, ram_wen;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(.MAX_DSTREAK(MAXD)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dhit(dhit),
        .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_store(ram_store), .ram_load(ram_load), .ram_ready(ram_ready)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr, dw;
        logic [31:0] da, ds;
        logic        rdy;
        logic [31:0] rl;
        logic        e_ren, e_wen;
        logic        ca;
        logic [31:0] e_addr;
        logic        cs;
        logic [31:0] e_store;
        logic        e_ihit;
        logic [31:0] e_iload;
        logic        e_dhit;
        logic [31:0] e_dload;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic row(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] ds, input logic rdy, input logic [31:0] rl,
                       input logic ren, input logic wen, input logic ca, input logic [31:0] addr,
                       input logic cs, input logic [31:0] store, input logic ih, input logic [31:0] il,
                       input logic dh, input logic [31:0] dl);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.ds = ds; v.rdy = rdy; v.rl = rl;
        v.e_ren = ren; v.e_wen = wen; v.ca = ca; v.e_addr = addr; v.cs = cs; v.e_store = store;
        v.e_ihit = ih; v.e_iload = il; v.e_dhit = dh; v.e_dload = dl;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        iREN = 0; dREN = 0; dWEN = 0; ram_ready = 0;
        iaddr = 0; daddr = 0; dstore = 0; ram_load = 0;
    endtask

    // behavioural reference: who owns the RAM port (0 none, 1 instr, 2 data read, 3 data write)
    int          m_owner, n_owner, m_streak, n_streak;
    logic [31:0] m_addr, n_addr, m_store, n_store;

    task automatic model_grant_d();
        n_owner = dWEN ? 3 : 2;
        n_addr  = daddr;
        n_store = dstore;
        n_streak = iREN ? ((m_streak + 1 > MAXD) ? MAXD : m_streak + 1) : 0;
    endtask

    task automatic model_grant_i();
        n_owner  = 1;
        n_addr   = iaddr;
        n_streak = 0;
    endtask

    task automatic model_check_and_step();
        logic dpend, e_ih, e_dh;
        dpend = dREN | dWEN;
        e_ih  = (m_owner == 1) && ram_ready && iREN;
        e_dh  = (m_owner >= 2) && ram_ready && dpend;
        chk("rnd_ram_ren", {31'd0, ram_ren}, {31'd0, (m_owner == 1 || m_owner == 2)});
        chk("rnd_ram_wen", {31'd0, ram_wen}, {31'd0, (m_owner == 3)});
        chk("rnd_ram_addr", ram_addr, m_addr);
        if (m_owner == 3) chk("rnd_ram_store", ram_store, m_store);
        chk("rnd_ihit", {31'd0, ihit}, {31'd0, e_ih});
        chk("rnd_iload", iload, e_ih ? ram_load : 32'd0);
        chk("rnd_dhit", {31'd0, dhit}, {31'd0, e_dh});
        chk("rnd_dload", dload, (e_dh && m_owner == 2) ? ram_load : 32'd0);
        n_owner = m_owner; n_streak = m_streak; n_addr = m_addr; n_store = m_store;
        if (m_owner == 0) begin
            if (dpend && !(m_streak == MAXD && iREN)) model_grant_d();
            else if (iREN) model_grant_i();
        end else if (ram_ready) begin
            n_owner = 0;
            if (m_owner == 1) begin
                if (dpend) model_grant_d();
            end else if (iREN) begin
                model_grant_i();
            end
        end
    endtask

    initial begin
        // reset values
        nRST = 0;
        idle_inputs();
        #3;
        chk("rst_ram_ren", {31'd0, ram_ren}, 32'd0);
        chk("rst_ram_wen", {31'd0, ram_wen}, 32'd0);
        chk("rst_ram_addr", ram_addr, 32'd0);
        chk("rst_ram_store", ram_store, 32'd0);
        chk("rst_ihit", {31'd0, ihit}, 32'd0);
        chk("rst_dhit", {31'd0, dhit}, 32'd0);
        chk("rst_iload", iload, 32'd0);
        chk("rst_dload", dload, 32'd0);
        @(negedge CLK);
        nRST = 1;

        // single 0-wait fetch, then ram_ready in IDLE ignored
        row(1, 32'h100, 0, 0, 0, 0, 0, 0,            0, 0, 1, 32'h0,   0, 0, 0, 0, 0, 0);
        row(1, 32'h100, 0, 0, 0, 0, 1, 32'h2402000A, 1, 0, 1, 32'h100, 0, 0, 1, 32'h2402000A, 0, 0);
        row(0, 0, 0, 0, 0, 0, 1, 32'h2402000A,       0, 0, 0, 0,       0, 0, 0, 0, 0, 0);
        // data beats instruction, 2-wait, then IACC chains directly
        row(1, 32'h200, 1, 0, 32'h80, 0, 0, 0,       0, 0, 0, 0,       0, 0, 0, 0, 0, 0);
        row(1, 32'h200, 1, 0, 32'h80, 0, 0, 0,       1, 0, 1, 32'h80,  0, 0, 0, 0, 0, 0);
        row(1, 32'h200, 1, 0, 32'h80, 0, 0, 0,       1, 0, 1, 32'h80,  0, 0, 0, 0, 0, 0);
        row(1, 32'h200, 1, 0, 32'h80, 0, 1, 32'h1111, 1, 0, 1, 32'h80, 0, 0, 0, 0, 1, 32'h1111);
        row(1, 32'h200, 0, 0, 32'h80, 0, 0, 0,       1, 0, 1, 32'h200, 0, 0, 0, 0, 0, 0);
        row(1, 32'h200, 0, 0, 32'h80, 0, 0, 0,       1, 0, 1, 32'h200, 0, 0, 0, 0, 0, 0);
        row(1, 32'h200, 0, 0, 32'h80, 0, 1, 32'h2222, 1, 0, 1, 32'h200, 0, 0, 1, 32'h2222, 0, 0);
        row(0, 0, 0, 0, 0, 0, 0, 0,                  0, 0, 0, 0,       0, 0, 0, 0, 0, 0);
        // write with dstore changing mid-access
        row(0, 0, 0, 1, 32'h40, 32'hDEADBEEF, 0, 0,  0, 0, 0, 0,       0, 0, 0, 0, 0, 0);
        row(0, 0, 0, 1, 32'h40, 32'h12345678, 0, 0,  0, 1, 1, 32'h40,  1, 32'hDEADBEEF, 0, 0, 0, 0);
        row(0, 0, 0, 1, 32'h40, 32'h12345678, 0, 0,  0, 1, 1, 32'h40,  1, 32'hDEADBEEF, 0, 0, 0, 0);
        row(0, 0, 0, 1, 32'h40, 32'h12345678, 1, 32'h5555, 0, 1, 1, 32'h40, 1, 32'hDEADBEEF, 0, 0, 1, 0);
        row(0, 0, 0, 0, 0, 0, 0, 0,                  0, 0, 0, 0,       0, 0, 0, 0, 0, 0);
        // iREN withdrawn during a 3-wait fetch
        row(1, 32'h300, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0,       0, 0, 0, 0, 0, 0);
        row(1, 32'h300, 0, 0, 0, 0, 0, 0,            1, 0, 1, 32'h300, 0, 0, 0, 0, 0, 0);
        row(0, 32'h300, 0, 0, 0, 0, 0, 0,            1, 0, 1, 32'h300, 0, 0, 0, 0, 0, 0);
        row(0, 32'h300, 0, 0, 0, 0, 0, 0,            1, 0, 1, 32'h300, 0, 0, 0, 0, 0, 0);
        row(0, 32'h300, 0, 0, 0, 0, 1, 32'h7777,     1, 0, 1, 32'h300, 0, 0, 0, 0, 0, 0);
        row(0, 0, 0, 0, 0, 0, 0, 0,                  0, 0, 0, 0,       0, 0, 0, 0, 0, 0);
        // streak: four data grants while iREN waits, then a forced instruction grant
        for (int g = 0; g < MAXD; g++) begin
            row(1, 32'h500, 1, 0, 32'h10 + g, 0, 0, 0,          0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            row(0, 32'h500, 1, 0, 32'h10 + g, 0, 1, 32'hC0 + g, 1, 0, 1, 32'h10 + g, 0, 0, 0, 0, 1, 32'hC0 + g);
        end
        row(1, 32'h500, 1, 0, 32'h99, 0, 0, 0,       0, 0, 0, 0,       0, 0, 0, 0, 0, 0);
        row(1, 32'h500, 1, 0, 32'h99, 0, 1, 32'hAAAA, 1, 0, 1, 32'h500, 0, 0, 1, 32'hAAAA, 0, 0);
        row(0, 32'h500, 1, 0, 32'h99, 0, 1, 32'hBBBB, 1, 0, 1, 32'h99, 0, 0, 0, 0, 1, 32'hBBBB);
        row(0, 0, 0, 0, 0, 0, 0, 0,                  0, 0, 0, 0,       0, 0, 0, 0, 0, 0);

        foreach (vecs[k]) begin
            @(posedge CLK);
            #1;
            iREN = vecs[k].ir; iaddr = vecs[k].ia; dREN = vecs[k].dr; dWEN = vecs[k].dw;
            daddr = vecs[k].da; dstore = vecs[k].ds; ram_ready = vecs[k].rdy; ram_load = vecs[k].rl;
            @(negedge CLK);
            chk($sformatf("v%0d_ram_ren", k), {31'd0, ram_ren}, {31'd0, vecs[k].e_ren});
            chk($sformatf("v%0d_ram_wen", k), {31'd0, ram_wen}, {31'd0, vecs[k].e_wen});
            if (vecs[k].ca) chk($sformatf("v%0d_ram_addr", k), ram_addr, vecs[k].e_addr);
            if (vecs[k].cs) chk($sformatf("v%0d_ram_store", k), ram_store, vecs[k].e_store);
            chk($sformatf("v%0d_ihit", k), {31'd0, ihit}, {31'd0, vecs[k].e_ihit});
            chk($sformatf("v%0d_iload", k), iload, vecs[k].e_iload);
            chk($sformatf("v%0d_dhit", k), {31'd0, dhit}, {31'd0, vecs[k].e_dhit});
            chk($sformatf("v%0d_dload", k), dload, vecs[k].e_dload);
        end

        // reset pulse in the middle of a write
        @(posedge CLK);
        #1;
        dWEN = 1; daddr = 32'h60; dstore = 32'hCAFE;
        @(posedge CLK);
        #1;
        chk("mid_rst_wen_before", {31'd0, ram_wen}, 32'd1);
        #2;
        nRST = 0;
        ram_ready = 1;
        #1;
        chk("mid_rst_wen_async", {31'd0, ram_wen}, 32'd0);
        chk("mid_rst_dhit", {31'd0, dhit}, 32'd0);
        chk("mid_rst_addr", ram_addr, 32'd0);
        @(negedge CLK);
        idle_inputs();
        nRST = 1;
        @(negedge CLK);
        chk("post_rst_wen", {31'd0, ram_wen}, 32'd0);
        chk("post_rst_ren", {31'd0, ram_ren}, 32'd0);
        chk("post_rst_dhit", {31'd0, dhit}, 32'd0);

        // randomized run against the reference model, starting from the post-reset state
        m_owner = 0; m_streak = 0; m_addr = 0; m_store = 0;
        n_owner = 0; n_streak = 0; n_addr = 0; n_store = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge CLK);
            m_owner = n_owner; m_streak = n_streak; m_addr = n_addr; m_store = n_store;
            #1;
            iREN      = ($urandom_range(0, 9) < 7);
            dREN      = ($urandom_range(0, 9) < 4);
            dWEN      = ($urandom_range(0, 9) < 3);
            ram_ready = ($urandom_range(0, 9) < 4);
            iaddr     = $urandom;
            daddr     = $urandom;
            dstore    = $urandom;
            ram_load  = $urandom;
            @(negedge CLK);
            model_check_and_step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
